// File: rtl/fifo_par_rr_sched.sv
// Round-robin packet scheduler over parity-protected ahead FIFOs.
// Pops one word per cycle into a registered valid/ready output stage.
module fifo_par_rr_sched #(
    parameter int CH_NUM     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int CH_W       = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CH_NUM-1:0]                ch_en,
    input  logic [CH_NUM-1:0]                ch_empty,
    input  logic [CH_NUM*(DATA_WIDTH+2)-1:0] ch_rdata,
    output logic [CH_NUM-1:0]                ch_ren,
    output logic                             out_vld,
    input  logic                             out_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_eop,
    output logic                             out_perr,
    output logic [CH_W-1:0]                  out_ch,
    input  logic [CH_NUM-1:0]                err_clr,
    output logic                             par_err,
    output logic [CH_NUM-1:0]                par_err_flag
);

    localparam int WW = DATA_WIDTH + 2;

    typedef enum logic {ARB, XFER} state_t;

    state_t              state;
    logic [CH_W-1:0]     gnt;
    logic [CH_W-1:0]     last_gnt;
    logic [CH_W-1:0]     sel;
    logic                sel_vld;
    logic [CH_NUM-1:0]   elig;
    logic [WW-1:0]       word;
    logic                pop;
    logic                perr;
    logic                eop_in;
    int                  idx;

    assign elig = ch_en & ~ch_empty & ~par_err_flag;

    // Scan from last_gnt+1 with an explicit wrap so non-power-of-2 counts work
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < CH_NUM; k++) begin
            idx = int'(last_gnt) + 1 + k;
            if (idx >= CH_NUM) idx = idx - CH_NUM;
            if (!sel_vld && elig[idx]) begin
                sel_vld = 1'b1;
                sel     = CH_W'(idx);
            end
        end
    end

    assign word   = ch_rdata[int'(gnt)*WW +: WW];
    assign perr   = ^word;
    assign eop_in = word[DATA_WIDTH];
    assign pop    = (state == XFER) && !ch_empty[gnt] && (!out_vld || out_rdy);
    assign ch_ren = pop ? (CH_NUM'(1) << gnt) : '0;
    assign par_err = pop && perr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ARB;
            gnt          <= '0;
            last_gnt     <= CH_W'(CH_NUM - 1);
            out_vld      <= 1'b0;
            out_data     <= '0;
            out_eop      <= 1'b0;
            out_perr     <= 1'b0;
            out_ch       <= '0;
            par_err_flag <= '0;
        end else begin
            // A set in the same cycle as a clear must win
            par_err_flag <= (par_err_flag & ~err_clr) | (par_err ? ch_ren : '0);
            unique case (state)
                ARB: begin
                    if (sel_vld) begin
                        gnt      <= sel;
                        last_gnt <= sel;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (pop && (eop_in || perr)) state <= ARB;
                end
                default: state <= ARB;
            endcase
            if (pop) begin
                out_vld  <= 1'b1;
                out_data <= word[DATA_WIDTH-1:0];
                out_eop  <= eop_in || perr;
                out_perr <= perr;
                out_ch   <= gnt;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule
